mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage that sits between the execute stage and write-back. It accepts the execute-stage pipeline registers, drives a single-port data memory through a req/ready handshake with byte-lane store alignment and load sign/zero extension, and stalls the upstream pipeline while the memory is busy. It also latches the MEM/WB pipeline registers and supplies the forwarding value back to execute.

## Interface
- `WAIT_LIMIT`, 255: maximum wait cycles per access before abort; 1..65535.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `EXE_pc_to_reg`  in  32  link value from execute.
- `EXE_ALU_out`  in  32  ALU result / effective address.
- `EXE_rs2_data`  in  32  store data.
- `EXE_rd_addr`  in  5  destination register.
- `EXE_funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `EXE_RDSrc`, `EXE_MemtoReg`, `EXE_MemRead`, `EXE_MemWrite`, `EXE_RegWrite`  in  1 each  control.
- `dm_req`  out  1  access request, held until `dm_ready`.
- `dm_addr`  out  32  word address, `{EXE_ALU_out[31:2],2'b00}`.
- `dm_we`  out  4  byte write enables; 0000 for loads.
- `dm_wdata`  out  32  lane-replicated store data.
- `dm_ready`  in  1  access complete this cycle.
- `dm_rdata`  in  32  read word, valid with `dm_ready`.
- `mem_stall`  out  1  freeze IF/ID/EXE this cycle.
- `mem_err`  out  1  one-cycle pulse: misaligned or timed-out access.
- `MEM_rd_data`  out  32  combinational forward value: `EXE_RDSrc ? EXE_pc_to_reg : EXE_ALU_out`.
- `WB_rd_result`, `WB_ld_data`  out  32 each  registered ALU/link result and extended load data.
- `WB_rd_addr`  out  5; `WB_MemtoReg`, `WB_RegWrite`  out  1 each  registered.

## Operation
- Access = `EXE_MemRead | EXE_MemWrite`; both set is treated as a store.
- FSM states IDLE, WAIT.
  - IDLE, no access: `dm_req`=0, no stall; WB registers load the instruction.
  - IDLE, access: `dm_req`=1 combinationally. If `dm_ready`=1 same cycle: complete, no stall. Else `mem_stall`=1, go WAIT, clear wait counter.
  - WAIT: `dm_req`=1, `mem_stall`=1 until `dm_ready`; on `dm_ready` complete, `mem_stall`=0 that cycle, go IDLE. Counter increments each WAIT cycle; reaching `WAIT_LIMIT` aborts: `dm_req` drops, `mem_err` pulses, bubble written, go IDLE.
- While stalled, WB registers load a bubble (`WB_RegWrite`=0) so no instruction writes back twice.
- Stores: lane = addr[1:0]. SB: wdata `{4{rs2[7:0]}}`, we `4'b0001<<lane`. SH: `{2{rs2[15:0]}}`, we `4'b0011<<{addr[1],1'b0}`. SW: rs2, we `4'b1111`.
- Loads: select byte `dm_rdata[8*lane+:8]` or half `dm_rdata[16*addr[1]+:16]`; B/H sign-extend, BU/HU zero-extend, W pass-through. Latched into `WB_ld_data` on completion.
- Upstream holds all `EXE_*` inputs stable while `mem_stall`=1.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, all `WB_*` = 0, `mem_err`=0; `dm_req`=0 and `mem_stall`=0 immediately on assertion.
- Reset during WAIT: request abandoned, no write-back, IDLE after release.
- Zero-wait access: 1 cycle, no stall. N-wait access: `mem_stall` high N cycles, WB updated on the (N+1)th edge.
- `dm_ready` while `dm_req`=0 is ignored.
- Misaligned abort (when checked): no request, no stall, `mem_err` pulses on the following cycle, bubble written.

## Configuration
- `MEM_MISALIGN_CHK_EN` defined: H at addr[0]=1 or W at addr[1:0]≠0 is never issued; `mem_err` pulses, bubble written, `WB_RegWrite`=0.
- Undefined: no check; W ignores addr[1:0], H ignores addr[0]; `mem_err` only reports timeout.

## Test plan
- SW rs2=0xDEADBEEF addr 0x104, `dm_ready` same cycle -> `dm_we`=1111, `dm_addr`=0x104, `mem_stall` never high.
- SB rs2=0x000000A5 addr 0x203 -> `dm_we`=1000, `dm_wdata`=0xA5A5A5A5.
- LB addr 0x102, `dm_rdata`=0x00800000, ready after 3 waits -> `mem_stall` high 3 cycles, `WB_ld_data`=0xFFFFFF80; LBU -> 0x00000080; exactly one write-back.
- LW `WAIT_LIMIT`=4, `dm_ready` never -> `dm_req` drops after 4 WAIT cycles, `mem_err` one pulse, `WB_RegWrite`=0.
- With `MEM_MISALIGN_CHK_EN`, LH addr 0x101 -> `dm_req`=0, `mem_err` pulse, no write-back; without it -> request to 0x100, low half returned.
- `rst` low during WAIT -> `dm_req`, `mem_stall` drop immediately; next ADD passes through unstalled after release.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: data-memory handshake, store lane alignment, load extension, MEM/WB registers.
// Optional misaligned-access abort is compiled in with `define MEM_MISALIGN_CHK_EN.
module mem_stage #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EXE_pc_to_reg,
  input  logic [31:0] EXE_ALU_out,
  input  logic [31:0] EXE_rs2_data,
  input  logic [4:0]  EXE_rd_addr,
  input  logic [2:0]  EXE_funct3,
  input  logic        EXE_RDSrc,
  input  logic        EXE_MemtoReg,
  input  logic        EXE_MemRead,
  input  logic        EXE_MemWrite,
  input  logic        EXE_RegWrite,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [31:0] MEM_rd_data,
  output logic [31:0] WB_rd_result,
  output logic [31:0] WB_ld_data,
  output logic [4:0]  WB_rd_addr,
  output logic        WB_MemtoReg,
  output logic        WB_RegWrite
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [15:0] LAST_WAIT = 16'(WAIT_LIMIT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q;
  logic        access, misalign, issue, timeout, done, bubble;
  logic [1:0]  lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign access = EXE_MemRead | EXE_MemWrite;
  assign lane   = EXE_ALU_out[1:0];

`ifdef MEM_MISALIGN_CHK_EN
  assign misalign = access & (((EXE_funct3[1:0] == 2'b01) & lane[0]) |
                              ((EXE_funct3[1:0] == 2'b10) & (lane != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign issue   = access & ~misalign;
  assign timeout = (state_q == WAIT) & ~dm_ready & (cnt_q == LAST_WAIT);

  // Gated by rst so request and stall fall the instant reset asserts.
  assign dm_req    = rst & issue;
  assign mem_stall = rst & issue & ~dm_ready & ~timeout;
  assign done      = dm_req & dm_ready;
  assign bubble    = misalign | timeout | mem_stall;

  assign dm_addr     = {EXE_ALU_out[31:2], 2'b00};
  assign MEM_rd_data = EXE_RDSrc ? EXE_pc_to_reg : EXE_ALU_out;
  assign mem_err     = err_q;

  always_comb begin
    dm_we    = 4'b0000;
    dm_wdata = EXE_rs2_data;
    case (EXE_funct3[1:0])
      2'b00: begin
        dm_wdata = {4{EXE_rs2_data[7:0]}};
        dm_we    = 4'b0001 << lane;
      end
      2'b01: begin
        dm_wdata = {2{EXE_rs2_data[15:0]}};
        dm_we    = 4'b0011 << {lane[1], 1'b0};
      end
      default: dm_we = 4'b1111;
    endcase
    if (!(EXE_MemWrite && issue)) dm_we = 4'b0000;
  end

  assign ld_byte = dm_rdata[{lane, 3'b000} +: 8];
  assign ld_half = dm_rdata[{lane[1], 4'b0000} +: 16];

  always_comb begin
    case (EXE_funct3[1:0])
      2'b00:   ld_ext = {{24{~EXE_funct3[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~EXE_funct3[2] & ld_half[15]}}, ld_half};
      default: ld_ext = dm_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (issue && !dm_ready) begin
        state_d = WAIT;
        cnt_d   = 16'd0;
      end
      default: if (!issue || dm_ready || timeout) state_d = IDLE;
               else cnt_d = cnt_q + 16'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      err_q        <= 1'b0;
      WB_rd_result <= 32'd0;
      WB_ld_data   <= 32'd0;
      WB_rd_addr   <= 5'd0;
      WB_MemtoReg  <= 1'b0;
      WB_RegWrite  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= misalign | timeout;
      WB_rd_result <= MEM_rd_data;
      WB_rd_addr   <= EXE_rd_addr;
      WB_MemtoReg  <= EXE_MemtoReg & ~bubble;
      WB_RegWrite  <= EXE_RegWrite & ~bubble;
      if (done && !EXE_MemWrite) WB_ld_data <= ld_ext;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed table-driven bench for mem_stage with multi-cycle handshake sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EXE_pc_to_reg, EXE_ALU_out, EXE_rs2_data;
  logic [4:0]  EXE_rd_addr;
  logic [2:0]  EXE_funct3;
  logic        EXE_RDSrc, EXE_MemtoReg, EXE_MemRead, EXE_MemWrite, EXE_RegWrite;
  logic        dm_req, dm_ready, mem_stall, mem_err;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, MEM_rd_data, WB_rd_result, WB_ld_data;
  logic [3:0]  dm_we;
  logic [4:0]  WB_rd_addr;
  logic        WB_MemtoReg, WB_RegWrite;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .EXE_pc_to_reg(EXE_pc_to_reg), .EXE_ALU_out(EXE_ALU_out), .EXE_rs2_data(EXE_rs2_data),
    .EXE_rd_addr(EXE_rd_addr), .EXE_funct3(EXE_funct3), .EXE_RDSrc(EXE_RDSrc),
    .EXE_MemtoReg(EXE_MemtoReg), .EXE_MemRead(EXE_MemRead), .EXE_MemWrite(EXE_MemWrite),
    .EXE_RegWrite(EXE_RegWrite),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_stall(mem_stall), .mem_err(mem_err), .MEM_rd_data(MEM_rd_data),
    .WB_rd_result(WB_rd_result), .WB_ld_data(WB_ld_data), .WB_rd_addr(WB_rd_addr),
    .WB_MemtoReg(WB_MemtoReg), .WB_RegWrite(WB_RegWrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        rd, wr, rw, rdsrc;
    logic [31:0] alu, rs2, pc, rdata;
    logic        exp_req;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata, exp_fwd, exp_ld;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic rd, input logic wr, input logic rw,
                       input logic rdsrc, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [31:0] pc);
    EXE_funct3 = f3; EXE_MemRead = rd; EXE_MemWrite = wr; EXE_RegWrite = rw;
    EXE_MemtoReg = rd; EXE_RDSrc = rdsrc; EXE_ALU_out = alu; EXE_rs2_data = rs2;
    EXE_pc_to_reg = pc; EXE_rd_addr = 5'd7;
  endtask

  task automatic drive_nop();
    drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  // Runs one load from a negedge for 10 cycles; the pipeline advances to a NOP once stall drops.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                          input int ready_at, output int n_req, output int n_stall,
                          output int n_err, output int n_wb, output logic [31:0] ld,
                          output logic [31:0] first_addr);
    logic adv, s;
    adv = 1'b0; n_req = 0; n_stall = 0; n_err = 0; n_wb = 0; ld = 32'hx; first_addr = 32'hx;
    drive(f3, 1'b1, 1'b0, 1'b1, 1'b0, addr, 32'h0, 32'h0);
    dm_rdata = rdata;
    for (int i = 0; i < 10; i++) begin
      dm_ready = !adv && (i == ready_at);
      #1;
      if (i == 0) first_addr = dm_addr;
      s = mem_stall;
      n_req += int'(dm_req);
      n_stall += int'(s);
      @(posedge clk); #1;
      n_wb += int'(WB_RegWrite);
      n_err += int'(mem_err);
      if (!adv && !s) ld = WB_ld_data;
      @(negedge clk);
      if (!adv && !s) begin
        adv = 1'b1;
        drive_nop();
      end
    end
    dm_ready = 1'b0;
  endtask

  vec_t vecs[10];
  int nr, ns, ne, nw;
  logic [31:0] ld, fa;

  initial begin
    vecs[0] = '{"sw",   3'b010, 0,1,0,0, 32'h104, 32'hDEADBEEF, 32'h0, 32'h0,        1, 4'b1111, 32'hDEADBEEF, 32'h104, 32'h0};
    vecs[1] = '{"sb",   3'b000, 0,1,0,0, 32'h203, 32'h000000A5, 32'h0, 32'h0,        1, 4'b1000, 32'hA5A5A5A5, 32'h203, 32'h0};
    vecs[2] = '{"sh",   3'b001, 0,1,0,0, 32'h102, 32'h1234BEEF, 32'h0, 32'h0,        1, 4'b1100, 32'hBEEFBEEF, 32'h102, 32'h0};
    vecs[3] = '{"lb",   3'b000, 1,0,1,0, 32'h102, 32'h0, 32'h0, 32'h00800000,        1, 4'b0000, 32'h0, 32'h102, 32'hFFFFFF80};
    vecs[4] = '{"lbu",  3'b100, 1,0,1,0, 32'h102, 32'h0, 32'h0, 32'h00800000,        1, 4'b0000, 32'h0, 32'h102, 32'h00000080};
    vecs[5] = '{"lh",   3'b001, 1,0,1,0, 32'h102, 32'h0, 32'h0, 32'h80010000,        1, 4'b0000, 32'h0, 32'h102, 32'hFFFF8001};
    vecs[6] = '{"lhu",  3'b101, 1,0,1,0, 32'h102, 32'h0, 32'h0, 32'h80010000,        1, 4'b0000, 32'h0, 32'h102, 32'h00008001};
    vecs[7] = '{"lb1",  3'b000, 1,0,1,0, 32'h101, 32'h0, 32'h0, 32'h00007F00,        1, 4'b0000, 32'h0, 32'h101, 32'h0000007F};
    vecs[8] = '{"lw",   3'b010, 1,0,1,0, 32'h108, 32'h0, 32'h0, 32'h12345678,        1, 4'b0000, 32'h0, 32'h108, 32'h12345678};
    vecs[9] = '{"jal",  3'b000, 0,0,1,1, 32'h55,  32'h0, 32'h1004, 32'hFFFFFFFF,     0, 4'b0000, 32'h0, 32'h1004, 32'h12345678};

    rst = 1'b0; dm_ready = 1'b0; dm_rdata = 32'h0;
    drive(3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0);
    #2;
    chk("rst_req", {31'd0, dm_req}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_wb_rw", {31'd0, WB_RegWrite}, 32'd0);
    chk("rst_wb_res", WB_rd_result, 32'd0);
    chk("rst_wb_ld", WB_ld_data, 32'd0);
    @(negedge clk); rst = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].f3, vecs[k].rd, vecs[k].wr, vecs[k].rw, vecs[k].rdsrc,
            vecs[k].alu, vecs[k].rs2, vecs[k].pc);
      dm_ready = 1'b1; dm_rdata = vecs[k].rdata;
      #1;
      chk({vecs[k].name, "_req"}, {31'd0, dm_req}, {31'd0, vecs[k].exp_req});
      chk({vecs[k].name, "_stall"}, {31'd0, mem_stall}, 32'd0);
      chk({vecs[k].name, "_we"}, {28'd0, dm_we}, {28'd0, vecs[k].exp_we});
      chk({vecs[k].name, "_fwd"}, MEM_rd_data, vecs[k].exp_fwd);
      if (vecs[k].exp_req) chk({vecs[k].name, "_addr"}, dm_addr, {vecs[k].alu[31:2], 2'b00});
      if (vecs[k].wr) chk({vecs[k].name, "_wdata"}, dm_wdata, vecs[k].exp_wdata);
      @(posedge clk); #1;
      chk({vecs[k].name, "_wb_rw"}, {31'd0, WB_RegWrite}, {31'd0, vecs[k].rw});
      chk({vecs[k].name, "_wb_res"}, WB_rd_result, vecs[k].exp_fwd);
      if (vecs[k].rd || !vecs[k].wr) chk({vecs[k].name, "_wb_ld"}, WB_ld_data, vecs[k].exp_ld);
      @(negedge clk);
    end
    dm_ready = 1'b0;
    drive_nop();
    @(negedge clk);

    run_load(3'b000, 32'h102, 32'h00800000, 3, nr, ns, ne, nw, ld, fa);
    chk("lb3_stall", ns, 3); chk("lb3_req", nr, 4); chk("lb3_wb", nw, 1);
    chk("lb3_err", ne, 0); chk("lb3_ld", ld, 32'hFFFFFF80);
    run_load(3'b100, 32'h102, 32'h00800000, 3, nr, ns, ne, nw, ld, fa);
    chk("lbu3_stall", ns, 3); chk("lbu3_wb", nw, 1); chk("lbu3_ld", ld, 32'h00000080);

    run_load(3'b010, 32'h100, 32'h0, -1, nr, ns, ne, nw, ld, fa);
    chk("to_req", nr, 5); chk("to_stall", ns, 4); chk("to_err", ne, 1); chk("to_wb", nw, 0);

    run_load(3'b001, 32'h101, 32'hAAAA8001, 0, nr, ns, ne, nw, ld, fa);
`ifdef MEM_MISALIGN_CHK_EN
    chk("mis_req", nr, 0); chk("mis_stall", ns, 0); chk("mis_err", ne, 1); chk("mis_wb", nw, 0);
`else
    chk("mis_req", nr, 1); chk("mis_addr", fa, 32'h100); chk("mis_err", ne, 0);
    chk("mis_wb", nw, 1); chk("mis_ld", ld, 32'hFFFF8001);
`endif

    drive(3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0);
    dm_ready = 1'b0;
    @(posedge clk); #2;
    chk("rw_stall_pre", {31'd0, mem_stall}, 32'd1);
    rst = 1'b0; #1;
    chk("rw_req", {31'd0, dm_req}, 32'd0);
    chk("rw_stall", {31'd0, mem_stall}, 32'd0);
    chk("rw_wb_rw", {31'd0, WB_RegWrite}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h77, 32'h0, 32'h0);
    #1;
    chk("add_req", {31'd0, dm_req}, 32'd0);
    chk("add_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    chk("add_wb_rw", {31'd0, WB_RegWrite}, 32'd1);
    chk("add_wb_res", WB_rd_result, 32'h77);
    chk("add_err", {31'd0, mem_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
